// File: rtl/oser16_train_tx.sv
// oser16_train_tx: transmit-side link trainer for an OSER16 serializer.
// Sends TRAIN_PAT until the far-end calibration flag is stable, then payload.
// A watchdog, a training request or loss of cal send the link back to training.
// Optional feature macro: OSER16_TX_STAT_EN adds the retrain_cnt statistics output.
module oser16_train_tx #(
  parameter int            FW        = 8,
  parameter logic [FW-1:0] TRAIN_PAT = 8'b0101_0101,
  parameter logic [FW-1:0] IDLE_PAT  = 8'b0000_1111,
  parameter int            HOLD_MIN  = 16,
  parameter int            STABLE    = 8,
  parameter int            RECAL_LEN = 4,
  parameter int            WD_W      = 12
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          cal,
  input  logic          train_req,
  input  logic [FW-1:0] din,
  input  logic          din_valid,
  output logic          din_ready,
  output logic [FW-1:0] d,
  output logic          recal,
  output logic          link_up,
`ifdef OSER16_TX_STAT_EN
  output logic [7:0]    retrain_cnt,
`endif
  output logic [2:0]    state
);

  localparam int HW = $clog2(HOLD_MIN + 1);
  localparam int SW = $clog2(STABLE + 1);
  localparam int RW = (RECAL_LEN > 1) ? $clog2(RECAL_LEN) : 1;
  localparam logic [HW-1:0]   HOLD_MAX = HW'(HOLD_MIN);
  localparam logic [SW-1:0]   STB_LAST = SW'(STABLE - 1);
  localparam logic [RW-1:0]   REC_LAST = RW'(RECAL_LEN - 1);
  localparam logic [WD_W-1:0] WD_MAX   = '1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TRAIN   = 3'd1,
    S_CONFIRM = 3'd2,
    S_DATA    = 3'd3,
    S_RECAL   = 3'd4
  } st_t;

  st_t            st, st_n;
  logic           cal_m, cal_s;
  logic [3:0]     idle_cnt;
  logic [HW-1:0]  hold_cnt;
  logic [SW-1:0]  stb_cnt;
  logic [RW-1:0]  rec_cnt;
  logic [WD_W-1:0] wd_cnt;
  logic           enter_recal, enter_train;

  assign state     = st;
  assign link_up   = (st == S_DATA);
  assign din_ready = (st == S_DATA);
  assign recal     = (st == S_RECAL);

  assign enter_recal = (st != S_RECAL) && (st_n == S_RECAL);
  assign enter_train = (st != S_TRAIN) && (st_n == S_TRAIN);

  // Two-flop synchroniser for the asynchronous cal flag.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      cal_m <= 1'b0;
      cal_s <= 1'b0;
    end else begin
      cal_m <= cal;
      cal_s <= cal_m;
    end
  end

  // State register.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) st <= S_IDLE;
    else     st <= st_n;
  end

  // Next-state logic; train_req wins in the active states, qualifying cal beats the watchdog.
  always_comb begin
    st_n = st;
    case (st)
      S_IDLE:    if (idle_cnt == 4'd9) st_n = S_TRAIN;
      S_TRAIN: begin
        if (train_req)                          st_n = S_RECAL;
        else if (cal_s && hold_cnt == HOLD_MAX) st_n = S_CONFIRM;
        else if (wd_cnt == WD_MAX)              st_n = S_RECAL;
      end
      S_CONFIRM: begin
        if (train_req)                st_n = S_RECAL;
        else if (!cal_s)              st_n = S_TRAIN;
        else if (stb_cnt == STB_LAST) st_n = S_DATA;
        else if (wd_cnt == WD_MAX)    st_n = S_RECAL;
      end
      S_DATA: begin
        if (train_req)   st_n = S_RECAL;
        else if (!cal_s) st_n = S_TRAIN;
      end
      S_RECAL:   if (rec_cnt == REC_LAST) st_n = S_TRAIN;
      default:   st_n = S_IDLE;
    endcase
  end

  // Phase counters; the watchdog saturates so a late expiry can never wrap.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
      hold_cnt <= '0;
      stb_cnt  <= '0;
      rec_cnt  <= '0;
      wd_cnt   <= '0;
    end else begin
      idle_cnt <= (st == S_IDLE && st_n == S_IDLE) ? idle_cnt + 4'd1 : '0;
      stb_cnt  <= (st == S_CONFIRM && st_n == S_CONFIRM) ? stb_cnt + 1'b1 : '0;
      rec_cnt  <= (st == S_RECAL && st_n == S_RECAL) ? rec_cnt + 1'b1 : '0;
      if (enter_recal || enter_train)
        hold_cnt <= '0;
      else if (st == S_TRAIN && hold_cnt != HOLD_MAX)
        hold_cnt <= hold_cnt + 1'b1;
      if (enter_recal || st == S_DATA || st == S_IDLE)
        wd_cnt <= '0;
      else if ((st == S_TRAIN || st == S_CONFIRM) && wd_cnt != WD_MAX)
        wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // Output word: payload path keyed on the current DATA state so the last accepted
  // word still goes out; otherwise the pattern of the state being entered.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst)
      d <= '0;
    else if (st == S_DATA)
      d <= din_valid ? din : IDLE_PAT;
    else if (st_n == S_IDLE)
      d <= '0;
    else
      d <= TRAIN_PAT;
  end

`ifdef OSER16_TX_STAT_EN
  // Retrain statistics: every RECAL entry and every DATA->TRAIN drop, saturating.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst)
      retrain_cnt <= '0;
    else if ((enter_recal || (st == S_DATA && st_n == S_TRAIN)) && retrain_cnt != 8'hFF)
      retrain_cnt <= retrain_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_oser16_train_tx.sv
// tb_oser16_train_tx: directed, table-driven bench for oser16_train_tx.
// Honors OSER16_TX_STAT_EN for the optional retrain_cnt output.
module tb_oser16_train_tx;
  logic       pclk = 1'b0;
  logic       rst, cal, train_req, din_valid;
  logic [7:0] din;
  logic       din_ready, recal, link_up;
  logic [7:0] d;
  logic [2:0] state;
`ifdef OSER16_TX_STAT_EN
  logic [7:0] retrain_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int bad;

  typedef struct {
    logic [7:0] din;
    logic       vld;
    logic [7:0] exp_d;
  } vec_t;
  vec_t tbl[6];

  oser16_train_tx dut (
    .pclk(pclk), .rst(rst), .cal(cal), .train_req(train_req),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .d(d), .recal(recal), .link_up(link_up),
`ifdef OSER16_TX_STAT_EN
    .retrain_cnt(retrain_cnt),
`endif
    .state(state)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  // Restart from IDLE after reset release: ten d=0 cycles, then TRAIN with 8'h55.
  task automatic idle_seq(input string tag);
    bad = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      if (state !== 3'd0 || d !== 8'h00) bad++;
    end
    chk({tag, "_idle_cycles"}, bad, 0);
    step();
    chk({tag, "_train_state"}, state, 1);
    chk({tag, "_train_d"}, d, 8'h55);
    chk({tag, "_train_recal"}, recal, 0);
    chk({tag, "_train_ready"}, din_ready, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{8'hA3, 1'b1, 8'hA3};
    tbl[1] = '{8'hA3, 1'b0, 8'h0F};
    tbl[2] = '{8'h3C, 1'b1, 8'h3C};
    tbl[3] = '{8'hFF, 1'b1, 8'hFF};
    tbl[4] = '{8'h00, 1'b1, 8'h00};
    tbl[5] = '{8'h77, 1'b0, 8'h0F};

    rst = 1'b0; cal = 1'b0; train_req = 1'b0; din = 8'h00; din_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_state", state, 0);
    chk("rst_d", d, 0);
    chk("rst_recal", recal, 0);
    chk("rst_link", link_up, 0);
    chk("rst_ready", din_ready, 0);
    step(); step();
    rst = 1'b0;

    // Power-up training
    idle_seq("t1");
    bad = 0;
    for (int i = 0; i < 19; i++) begin
      step();
      if (state !== 3'd1 || d !== 8'h55 || din_ready !== 1'b0) bad++;
    end
    chk("t1_train_hold", bad, 0);

    // cal rises: 2 sync cycles, CONFIRM on the 3rd edge, DATA after 8 more
    cal = 1'b1;
    step(); step();
    chk("t2_sync_latency", state, 1);
    step();
    chk("t2_confirm", state, 2);
    for (int i = 0; i < 7; i++) step();
    chk("t2_confirm_last", state, 2);
    step();
    chk("t2_data", state, 3);
    chk("t2_link", link_up, 1);
    chk("t2_ready", din_ready, 1);
    chk("t2_first_d", d, 8'h55);

    // Payload vectors
    for (int i = 0; i < 6; i++) begin
      din = tbl[i].din;
      din_valid = tbl[i].vld;
      step();
      chk($sformatf("data_vec%0d_d", i), d, tbl[i].exp_d);
      chk($sformatf("data_vec%0d_link", i), link_up, 1);
    end

    // train_req in DATA with a valid word: word still goes out, then RECAL x4
    din = 8'h5A; din_valid = 1'b1; train_req = 1'b1;
    step();
    train_req = 1'b0; din_valid = 1'b0;
    chk("t5_state", state, 4);
    chk("t5_last_word", d, 8'h5A);
    chk("t5_ready", din_ready, 0);
    chk("t5_link", link_up, 0);
    chk("t5_recal", recal, 1);
`ifdef OSER16_TX_STAT_EN
    chk("t5_retrain_cnt", retrain_cnt, 1);
`endif
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (state !== 3'd4 || recal !== 1'b1 || d !== 8'h55) bad++;
    end
    chk("t5_recal_len", bad, 0);
    step();
    chk("t5_back_train", state, 1);
    chk("t5_recal_off", recal, 0);
    chk("t5_train_d", d, 8'h55);

    // hold_cnt restarted: 17 TRAIN cycles, then CONFIRM
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (state !== 3'd1) bad++;
    end
    chk("t3_hold_min", bad, 0);
    step();
    chk("t3_confirm", state, 2);
    // cal glitch so that cal_s=0 while stb_cnt=5
    step(); step(); step();
    cal = 1'b0;
    step();
    cal = 1'b1;
    step();
    chk("t3_confirm_stb5", state, 2);
    step();
    chk("t3_glitch_train", state, 1);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (state !== 3'd1) bad++;
    end
    chk("t3_retrain_hold", bad, 0);
    step();
    chk("t3_reconfirm", state, 2);
    for (int i = 0; i < 7; i++) step();
    chk("t3_stable_wait", state, 2);
    step();
    chk("t3_data", state, 3);

    // cal falls in DATA while train_req asserts in the same cycle -> RECAL
    cal = 1'b0;
    step();
    chk("sim_data_d1", state, 3);
    step();
    chk("sim_data_d2", state, 3);
    train_req = 1'b1;
    step();
    chk("sim_recal", state, 4);
    // train_req held as a level: one TRAIN cycle, then RECAL again
    step(); step(); step();
    chk("lvl_recal_end", state, 4);
    step();
    chk("lvl_train_gap", state, 1);
    step();
    chk("lvl_recal_again", state, 4);
    train_req = 1'b0;
`ifdef OSER16_TX_STAT_EN
    chk("lvl_retrain_cnt", retrain_cnt, 3);
`endif
    step();
    chk("t6_recal_cyc2", state, 4);

    // Asynchronous reset mid-cycle during RECAL
    #2 rst = 1'b1;
    #1;
    chk("t6_async_state", state, 0);
    chk("t6_async_recal", recal, 0);
    chk("t6_async_d", d, 0);
    chk("t6_async_link", link_up, 0);
`ifdef OSER16_TX_STAT_EN
    chk("t6_async_cnt", retrain_cnt, 0);
`endif
    step();
    rst = 1'b0;
    idle_seq("t6");

    // Watchdog with cal held 0: TRAIN cycles 0..4095, then RECAL
    bad = 0;
    for (int i = 0; i < 4095; i++) begin
      step();
      if (state !== 3'd1 || recal !== 1'b0) bad++;
    end
    chk("t4_wd_train_hold", bad, 0);
    step();
    chk("t4_wd_recal", state, 4);
    chk("t4_wd_recal_out", recal, 1);
    chk("t4_wd_recal_d", d, 8'h55);
    step(); step(); step();
    chk("t4_wd_recal_last", recal, 1);
    step();
    chk("t4_wd_train", state, 1);
    chk("t4_wd_train_recal", recal, 0);
    chk("t4_wd_train_d", d, 8'h55);

    // Watchdog restarted from 0; cal qualifies exactly at expiry -> CONFIRM
    for (int i = 0; i < 4093; i++) step();
    cal = 1'b1;
    step(); step();
    chk("wd_cal_tie_pre", state, 1);
    step();
    chk("wd_cal_tie_confirm", state, 2);
    step();
    chk("wd_expired_confirm", state, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
